vc_fifo: RTL
============

VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter DATAW, default 32: flit payload width in bits.
REQ-002 Parameter DEPTH, default 4: flit slots per virtual channel; any integer >= 2, not restricted to powers of two.
REQ-003 Parameter NUM_VC, default 2: number of independent virtual-channel queues; >= 1.
REQ-004 Parameter PKTLEN, default 4: flits per packet, used for ordy; 1 <= PKTLEN <= DEPTH.
REQ-005 clk  input  1: single clock; all state updates on rising edge.
REQ-006 rst_n  input  1: asynchronous, active-low reset.
REQ-007 idata  input  DATAW: write flit.
REQ-008 wr_vc  input  clog2(NUM_VC) (min 1): target VC of write.
REQ-009 wr_en  input  1: write request.
REQ-010 rd_vc  input  clog2(NUM_VC) (min 1): VC selected for read and odata.
REQ-011 rd_en  input  1: read (pop) request.
REQ-012 clr_err  input  1: clears sticky error flags.
REQ-013 odata  output  DATAW: head flit of rd_vc queue.
REQ-014 empty  output  NUM_VC: per-VC empty.
REQ-015 full  output  NUM_VC: per-VC full.
REQ-016 ordy  output  NUM_VC: per-VC room for one whole packet.
REQ-017 credit  output  NUM_VC: per-VC one-cycle credit-return pulse.
REQ-018 ovf_err  output  1: sticky overflow flag.
REQ-019 udf_err  output  1: sticky underflow flag.

Function
REQ-020 Each VC SHALL hold a circular queue with write pointer, read pointer and occupancy count cnt[v] of width clog2(DEPTH+1); pointers wrap from DEPTH-1 to 0.
REQ-021 Read accepted (rd_ok) iff rd_en & ~empty[rd_vc]; rd_ok advances rd pointer of rd_vc.
REQ-022 Write accepted (wr_ok) iff wr_en & (~full[wr_vc] | (rd_ok & rd_vc==wr_vc)); wr_ok stores idata at wr pointer of wr_vc and advances it.
REQ-023 cnt[v] SHALL +1 on wr_ok only to v, -1 on rd_ok only from v, unchanged when both hit v or neither.
REQ-024 Writes and reads to different VCs in one cycle SHALL both take effect independently.
REQ-025 No write-to-read bypass: a write to an empty VC is visible on odata the next cycle, never the same cycle.
REQ-026 empty[v] = (cnt[v]==0); full[v] = (cnt[v]==DEPTH); ordy[v] = ((DEPTH - cnt[v]) >= PKTLEN); all combinational from registered count.
REQ-027 odata SHALL be combinational head of rd_vc when ~empty[rd_vc], else all zeros.
REQ-028 credit[v] SHALL be registered: asserted exactly one cycle after each rd_ok from v, for one cycle; at most one bit set per cycle.
REQ-029 Write with wr_en to a full VC not concurrently read SHALL be dropped with no state change and set ovf_err the next cycle.
REQ-030 rd_en on an empty rd_vc SHALL leave state unchanged and set udf_err the next cycle.
REQ-031 ovf_err/udf_err SHALL remain set until clr_err; clr_err and a new error in the same cycle leave the flag set.
REQ-032 rd_vc/wr_vc values >= NUM_VC SHALL be treated as no request and set the matching error flag.

Reset
REQ-033 On rst_n low, immediately and independent of clk: all pointers and counts 0, credit 0, ovf_err 0, udf_err 0; hence empty all 1, full all 0, ordy all 1, odata 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued flits; storage array need not be cleared.
REQ-035 First accepted operation SHALL be on the first rising edge after rst_n deasserts.

Verification (DATAW=8, DEPTH=4, NUM_VC=2, PKTLEN=2)
REQ-036 Write 0x11,0x22,0x33 to VC0 -> ordy[0] falls after 3rd write, empty[0]=0; rd_vc=0 odata=0x11; three reads return 0x11,0x22,0x33, credit[0] pulses cycle after each read.
REQ-037 Fill VC1 with 4 flits -> full[1]=1; 5th write alone dropped, ovf_err=1 next cycle; same write concurrent with VC1 read -> accepted, cnt stays 4.
REQ-038 Interleave writes VC0/VC1 and reads VC1 same cycle -> per-VC order preserved, VC0 unaffected by VC1 reads.
REQ-039 Wrap: 10 write/read pairs on VC0 -> data sequence intact across pointer wrap 3->0.
REQ-040 rd_en on empty VC0 -> udf_err=1, odata=0; clr_err -> 0 next cycle.
REQ-041 Assert rst_n low between clock edges with VC0 holding 2 flits -> empty=2'b11, credit=0 without a clock edge.

Source files
------------

// File: rtl/vc_fifo.sv
// Multi-virtual-channel flit FIFO: NUM_VC independent circular queues sharing one
// write port and one read port, with per-VC status, credit return and sticky errors.
module vc_fifo #(
  parameter int DATAW  = 32,
  parameter int DEPTH  = 4,
  parameter int NUM_VC = 2,
  parameter int PKTLEN = 4,
  localparam int VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATAW-1:0]  idata,
  input  logic [VCW-1:0]    wr_vc,
  input  logic              wr_en,
  input  logic [VCW-1:0]    rd_vc,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATAW-1:0]  odata,
  output logic [NUM_VC-1:0] empty,
  output logic [NUM_VC-1:0] full,
  output logic [NUM_VC-1:0] ordy,
  output logic [NUM_VC-1:0] credit,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_PKT  = CW'(PKTLEN);

  logic [DATAW-1:0]  mem_q    [NUM_VC][DEPTH];
  logic [PW-1:0]     wr_ptr_q [NUM_VC];
  logic [PW-1:0]     wr_ptr_d [NUM_VC];
  logic [PW-1:0]     rd_ptr_q [NUM_VC];
  logic [PW-1:0]     rd_ptr_d [NUM_VC];
  logic [CW-1:0]     cnt_q    [NUM_VC];
  logic [CW-1:0]     cnt_d    [NUM_VC];
  logic [NUM_VC-1:0] credit_q, credit_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wr_vc_ok, rd_vc_ok;
  logic [VCW-1:0]    wr_idx, rd_idx;
  logic              wr_ok, rd_ok;
  logic [NUM_VC-1:0] wr_hit, rd_hit;

  // A VC select outside 0..NUM_VC-1 is a non-request; only reachable when
  // NUM_VC is not a power of two.
  if (NUM_VC == (1 << VCW)) begin : g_vc_full_range
    assign wr_vc_ok = 1'b1;
    assign rd_vc_ok = 1'b1;
  end else begin : g_vc_partial_range
    assign wr_vc_ok = (wr_vc < VCW'(NUM_VC));
    assign rd_vc_ok = (rd_vc < VCW'(NUM_VC));
  end

  assign wr_idx = wr_vc_ok ? wr_vc : '0;
  assign rd_idx = rd_vc_ok ? rd_vc : '0;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v] = (cnt_q[v] == '0);
      full[v]  = (cnt_q[v] == CNT_FULL);
      ordy[v]  = ((CNT_FULL - cnt_q[v]) >= CNT_PKT);
    end
  end

  // Accept rules: a read pops when rd_en targets a valid non-empty VC; a write
  // pushes when wr_en targets a valid VC that is not full, or that is full but
  // popped by the same cycle's read. Anything else is refused and flagged.
  assign rd_ok = rd_en & rd_vc_ok & ~empty[rd_idx];
  assign wr_ok = wr_en & wr_vc_ok & (~full[wr_idx] | (rd_ok & (rd_idx == wr_idx)));

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = wr_ok && (wr_idx == VCW'(v));
      rd_hit[v] = rd_ok && (rd_idx == VCW'(v));
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      if (wr_hit[v]) begin
        wr_ptr_d[v] = (wr_ptr_q[v] == PTR_LAST) ? '0 : wr_ptr_q[v] + 1'b1;
      end
      if (rd_hit[v]) begin
        rd_ptr_d[v] = (rd_ptr_q[v] == PTR_LAST) ? '0 : rd_ptr_q[v] + 1'b1;
      end
      case ({wr_hit[v], rd_hit[v]})
        2'b10:   cnt_d[v] = cnt_q[v] + 1'b1;
        2'b01:   cnt_d[v] = cnt_q[v] - 1'b1;
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
    credit_d = rd_hit;
    // Set wins over clear so an error in the clearing cycle is not lost.
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_ok);
    udf_d = (udf_q & ~clr_err) | (rd_en & ~rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      credit_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; stale slots are unreachable once counts are zero.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_idx][wr_ptr_q[wr_idx]] <= idata;
    end
  end

  always_comb begin
    odata = '0;
    if (rd_vc_ok && !empty[rd_idx]) begin
      odata = mem_q[rd_idx][rd_ptr_q[rd_idx]];
    end
  end

  assign credit  = credit_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule
